// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the
// in-order ALU/commit path (A) and the long-latency load/mul path (B).
//
// Ports:
//   clock, reset      : rising-edge clock, async active-low reset
//   a_valid/addr/data : requester A write request; a_ready = accepted
//   b_valid/addr/data : requester B write request; b_ready = accepted
//   reg_wr/waddr/wdata: registered write port to the register file
//   q_addr            : decode-stage forwarding query address
//   q_pending/q_data  : staged write hits q_addr / staged data
//   starve_cnt        : cycles B has waited while A was granted
module regfile_wb_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int STARVE_MAX = 3,
   localparam int CW        = $clog2(STARVE_MAX + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic              reg_wr,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] q_addr,
   output logic              q_pending,
   output logic [DATA_W-1:0] q_data,
   output logic [CW-1:0]     starve_cnt
);

   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic              force_b;
   logic              gnt_a, gnt_b;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_data;

   // B overrides A once it has waited STARVE_MAX cycles
   assign force_b = b_valid && (cnt_q == CNT_MAX);
   assign gnt_a   = a_valid && !force_b;
   assign gnt_b   = b_valid && !gnt_a;

   assign a_ready = gnt_a;
   assign b_ready = gnt_b;

   assign acc_addr = gnt_a ? a_addr : b_addr;
   assign acc_data = gnt_a ? a_data : b_data;

   always_comb begin
      cnt_d   = '0;
      wr_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (b_valid && gnt_a) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end
      // x0 writes are consumed but never reach the register file
      if ((gnt_a || gnt_b) && (acc_addr != '0)) begin
         wr_d    = 1'b1;
         waddr_d = acc_addr;
         wdata_d = acc_data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         wr_q    <= wr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
      end
   end

   assign reg_wr     = wr_q;
   assign waddr      = waddr_q;
   assign wdata      = wdata_q;
   assign starve_cnt = cnt_q;

   assign q_pending = wr_q && (waddr_q == q_addr) && (q_addr != '0);
   assign q_data    = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench for regfile_wb_arbiter.
// Directed scenarios, randomized requesters, async reset mid-write.
module tb_regfile_wb_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int SM = 3;
   localparam int CW = $clog2(SM + 1);

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          a_valid = 1'b0;
   logic [AW-1:0] a_addr = '0;
   logic [DW-1:0] a_data = '0;
   logic          a_ready;
   logic          b_valid = 1'b0;
   logic [AW-1:0] b_addr = '0;
   logic [DW-1:0] b_data = '0;
   logic          b_ready;
   logic          reg_wr;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [AW-1:0] q_addr = '0;
   logic          q_pending;
   logic [DW-1:0] q_data;
   logic [CW-1:0] starve_cnt;

   regfile_wb_arbiter #(
      .DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SM)
   ) dut (
      .clock(clock), .reset(reset),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
      .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata),
      .q_addr(q_addr), .q_pending(q_pending), .q_data(q_data),
      .starve_cnt(starve_cnt)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb[$];
   int            vecs = 0;
   int            errs = 0;
   bit            mon_en = 1'b0;
   int            m_wait = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;
   bit            acc_a = 1'b0;
   bit            acc_b = 1'b0;
   logic [DW-1:0] rf [32];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: each cycle pops the expectation for the currently staged write
   always @(negedge clock) begin
      if (mon_en) begin
         exp_t e;
         if (sb.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL scoreboard_empty: got none expected entry at %0t", $time);
         end else begin
            e = sb.pop_front();
            chk("reg_wr", reg_wr, e.wr);
            chk("waddr", waddr, e.addr);
            chk("wdata", wdata, e.data);
            chk("q_data", q_data, e.data);
            chk("q_pending", q_pending,
                e.wr && (e.addr == q_addr) && (q_addr != 0));
            if (reg_wr) rf[waddr] = wdata;
         end
      end
   end

   // Reference model: B is forced after waiting SM cycles, else A first.
   task automatic step();
      bit            fb, ga, gb;
      logic [AW-1:0] ad;
      logic [DW-1:0] dt;
      bit            wr;
      @(negedge clock);
      #2;
      fb = b_valid && (m_wait >= SM);
      ga = a_valid && !fb;
      gb = b_valid && !ga;
      chk("a_ready", a_ready, ga);
      chk("b_ready", b_ready, gb);
      chk("starve_cnt", starve_cnt, m_wait);
      wr = 1'b0;
      if (ga || gb) begin
         ad = ga ? a_addr : b_addr;
         dt = ga ? a_data : b_data;
         if (ad != 0) begin
            wr     = 1'b1;
            m_addr = ad;
            m_data = dt;
         end
      end
      sb.push_back({wr, m_addr, m_data});
      if (b_valid && ga) m_wait = (m_wait + 1 > SM) ? SM : m_wait + 1;
      else               m_wait = 0;
      acc_a = ga;
      acc_b = gb;
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic start_model();
      sb.delete();
      m_wait = 0;
      m_addr = '0;
      m_data = '0;
      sb.push_back({1'b0, m_addr, m_data});
      mon_en = 1'b1;
   endtask

   initial begin
      int nb;
      for (int i = 0; i < 32; i++) rf[i] = '0;

      // Reset state
      #3;
      chk("rst_reg_wr", reg_wr, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_starve", starve_cnt, 0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      start_model();

      // A only
      a_valid = 1'b1; a_addr = 5; a_data = 32'hDEADBEEF;
      step();
      idle_inputs();
      step();
      step();

      // x0 filter
      b_valid = 1'b1; b_addr = 0; b_data = 32'h1234;
      step();
      idle_inputs();
      step();
      step();

      // Starvation: both held valid
      a_valid = 1'b1; a_addr = 1; a_data = 32'hA1;
      b_valid = 1'b1; b_addr = 2; b_data = 32'hB2;
      nb = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         nb += int'(acc_b);
      end
      chk("starve_b_share", nb, 2);

      // Same-address collision
      a_valid = 1'b1; a_addr = 7; a_data = 32'h11;
      b_valid = 1'b1; b_addr = 7; b_data = 32'h22;
      step();
      a_valid = 1'b0;
      step();
      idle_inputs();
      step();
      step();
      chk("collision_x7", rf[7], 32'h22);

      // Forwarding
      a_valid = 1'b1; a_addr = 9; a_data = 32'hCAFE;
      step();
      q_addr = 9;
      step();
      q_addr = 8;
      step();
      q_addr = 0;
      idle_inputs();
      step();

      // Randomized requesters holding requests until accepted
      for (int i = 0; i < 400; i++) begin
         if (!a_valid || acc_a) begin
            a_valid = ($urandom_range(0, 3) != 0);
            a_addr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            a_data  = $urandom;
         end
         if (!b_valid || acc_b) begin
            b_valid = ($urandom_range(0, 2) != 0);
            b_addr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            b_data  = $urandom;
         end
         q_addr = ($urandom_range(0, 1) == 0) ? m_addr : AW'($urandom);
         step();
      end

      // Async reset while a write is staged and B is waiting
      idle_inputs();
      step();
      a_valid = 1'b1; a_addr = 3; a_data = 32'hABCD;
      b_valid = 1'b1; b_addr = 4; b_data = 32'h4444;
      step();
      idle_inputs();
      mon_en = 1'b0;
      #1;
      chk("pre_rst_reg_wr", reg_wr, 1);
      chk("pre_rst_starve", starve_cnt, 1);
      reset = 1'b0;
      #1;
      chk("arst_reg_wr", reg_wr, 0);
      chk("arst_waddr", waddr, 0);
      chk("arst_wdata", wdata, 0);
      chk("arst_starve", starve_cnt, 0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      start_model();
      step();
      step();
      a_valid = 1'b1; a_addr = 6; a_data = 32'h66;
      b_valid = 1'b1; b_addr = 8; b_data = 32'h88;
      for (int i = 0; i < 5; i++) step();
      idle_inputs();
      step();
      step();
      @(negedge clock);
      #1;
      mon_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between two writeback requesters. Requester A is the in-order ALU/commit path. Requester B is the long-latency path (load/multiply unit). The block arbitrates with A-priority plus a starvation guard, filters writes to x0, and stages the winner in an output register that drives the register file's reg_wr/waddr/wdata. It also exposes a pending-write query so the decode stage can forward the staged value.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, width of register address
STARVE_MAX, 3, consecutive cycles B may wait while A is granted before B is forced to win (must be >= 1)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
a_valid  input  1  requester A has a write
a_addr  input  ADDR_W  A destination register
a_data  input  DATA_W  A write data
a_ready  output  1  A write accepted this cycle
b_valid  input  1  requester B has a write
b_addr  input  ADDR_W  B destination register
b_data  input  DATA_W  B write data
b_ready  output  1  B write accepted this cycle
reg_wr  output  1  write enable to register file
waddr  output  ADDR_W  write address to register file
wdata  output  DATA_W  write data to register file
q_addr  input  ADDR_W  forwarding query address
q_pending  output  1  staged write targets q_addr
q_data  output  DATA_W  staged write data (equals wdata)
starve_cnt  output  $clog2(STARVE_MAX+1)  B wait counter, for observability

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0, async): reg_wr=0, waddr=0, wdata=0, starve_cnt=0. A staged write is discarded, not written. Ready outputs follow the grant logic; they are combinational from valids and starve_cnt.
- Grant (combinational, same cycle):
  - b_valid && starve_cnt==STARVE_MAX -> B granted.
  - else a_valid -> A granted.
  - else b_valid -> B granted.
  - else no grant.
- a_ready/b_ready = grant to that requester. Never both 1. A handshake completes when valid && ready on a rising edge.
- Requesters hold valid/addr/data stable until ready. The arbiter does not latch unaccepted requests.
- Starvation counter, updated at each edge:
  - If b_valid && A granted: starve_cnt = min(starve_cnt+1, STARVE_MAX).
  - If B granted or b_valid==0: starve_cnt = 0.
- Output stage, loaded at the edge of an accepted transfer:
  - If the accepted addr != 0: reg_wr=1, waddr=addr, wdata=data, valid for exactly the next cycle.
  - If the accepted addr == 0: the request is still consumed (ready=1), but reg_wr=0 next cycle. waddr/wdata hold their previous values.
  - No accepted transfer: reg_wr=0 next cycle; waddr/wdata hold.
- Latency: accept at edge N -> reg_wr high during cycle N..N+1 -> register file updates at edge N+1. Throughput is one write per cycle. There is no backpressure from the register file.
- Forwarding: q_pending = reg_wr && (waddr==q_addr) && (q_addr!=0). q_data = wdata. Purely combinational.
- Same-address collision: writes retire in grant order, so the later-granted write is the final value. No merging.
- Both valid forever: A wins STARVE_MAX consecutive cycles, then B wins one cycle, and the counter resets. Steady-state B share is 1/(STARVE_MAX+1).
- Reset asserted mid-stream: outputs are cleared immediately (async). After deassertion, the first edge behaves as from idle with starve_cnt=0.

Test Plan:
1. Reset then A only: a_valid=1, a_addr=5, a_data=0xDEADBEEF at edge 1 -> a_ready=1 in cycle 0; reg_wr=1, waddr=5, wdata=0xDEADBEEF in cycle 1; reg_wr=0 in cycle 2 with no further valid.
2. x0 filter: b_valid=1, b_addr=0, b_data=0x1234, A idle -> b_ready=1; next cycle reg_wr=0, waddr/wdata unchanged.
3. Starvation, STARVE_MAX=3, a_valid and b_valid held high with distinct addrs -> grant sequence A,A,A,B,A,A,A,B. starve_cnt reads 0,1,2,3,0,1,2,3. reg_wr=1 every cycle after the first accept.
4. Collision: A writes x7=0x11 and B writes x7=0x22 in the same cycle with starve_cnt=0 -> A staged first, then B. The register file ends with x7=0x22.
5. Forwarding: staged write x9=0xCAFE, q_addr=9 -> q_pending=1, q_data=0xCAFE. q_addr=0 or 8 -> q_pending=0.
6. Async reset mid-write: reset driven 0 between edges while reg_wr=1 -> reg_wr, waddr, wdata and starve_cnt go to 0 without a clock edge. After release with no valid, reg_wr stays 0.
